bcd_counter_nd: RTL and testbench

//   Parametrised N-digit synchronous BCD up/down counter; successor to the per-digit cascaded counter.
//   All digits share one clock; inter-digit carry is a combinational count-enable, not a rippled clock.

---
 rtl/bcd_counter_nd.sv | 112 +++++++++++
 tb/tb_bcd_counter_nd.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_nd.sv
// N-digit synchronous BCD up/down counter with load, sticky overflow and optional saturation.
// Define BCD_CNT_LATCH_EN to add the latch/q_latch capture register.
module bcd_counter_nd #(
    parameter int NUM_DIGITS = 6,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ena,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
`ifdef BCD_CNT_LATCH_EN
    input  logic                    latch,
    output logic [4*NUM_DIGITS-1:0] q_latch,
`endif
    output logic [4*NUM_DIGITS-1:0] q,
    output logic                    carry_out,
    output logic                    ovf
);

    logic [4*NUM_DIGITS-1:0] q_q, q_d;
    logic                    carry_q, carry_d;
    logic                    ovf_q, ovf_d;
    logic [4*NUM_DIGITS-1:0] step_val;
    logic [4*NUM_DIGITS-1:0] load_clamped;
    logic [3:0]              dig;
    logic [3:0]              ldig;
    logic                    run;
    logic                    term;

    // run carries "all lower digits are at their rollover value" up the chain
    always_comb begin
        step_val = q_q;
        run      = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = q_q[4*i +: 4];
            if (up_dn) begin
                if (run) step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                run = run & (dig == 4'd9);
            end else begin
                if (run) step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                run = run & (dig == 4'd0);
            end
        end
        term = run;
    end

    always_comb begin
        load_clamped = '0;
        ldig         = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ldig = load_val[4*i +: 4];
            load_clamped[4*i +: 4] = (ldig > 4'd9) ? 4'd9 : ldig;
        end
    end

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            q_d   = load_clamped;
            ovf_d = 1'b0;
        end else if (ena) begin
            if (term) begin
                ovf_d = 1'b1;
                if (!SATURATE) begin
                    q_d     = step_val;
                    carry_d = 1'b1;
                end
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q         = q_q;
    assign carry_out = carry_q;
    assign ovf       = ovf_q;

`ifdef BCD_CNT_LATCH_EN
    logic [4*NUM_DIGITS-1:0] q_latch_q, q_latch_d;

    // a capture wins over clear so a gate-end latch+clr keeps the final count
    always_comb begin
        q_latch_d = q_latch_q;
        if (latch)    q_latch_d = q_q;
        else if (clr) q_latch_d = '0;
    end

    always_ff @(posedge clk) begin
        q_latch_q <= q_latch_d;
    end

    assign q_latch = q_latch_q;
`endif

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Self-checking bench for bcd_counter_nd: wrap and saturate instances against an integer model.
module tb_bcd_counter_nd;

    localparam int ND  = 6;
    localparam int MAX = 999999;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          ena = 1'b0;
    logic          up_dn = 1'b1;
    logic          load = 1'b0;
    logic [23:0]   load_val = '0;
    logic          latch = 1'b0;
    logic [23:0]   q0, q1;
    logic          c0, c1, o0, o1;
    logic [23:0]   ql0, ql1;

    int errors = 0;
    int checks = 0;

    int        m_cnt [2];
    bit        m_car [2];
    bit        m_ovf [2];
    bit [23:0] m_lat [2];

    always #5 clk = ~clk;

`ifdef BCD_CNT_LATCH_EN
    bcd_counter_nd #(.NUM_DIGITS(ND), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
        .load_val(load_val), .latch(latch), .q_latch(ql0),
        .q(q0), .carry_out(c0), .ovf(o0));
    bcd_counter_nd #(.NUM_DIGITS(ND), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
        .load_val(load_val), .latch(latch), .q_latch(ql1),
        .q(q1), .carry_out(c1), .ovf(o1));
`else
    assign ql0 = '0;
    assign ql1 = '0;
    bcd_counter_nd #(.NUM_DIGITS(ND), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q0), .carry_out(c0), .ovf(o0));
    bcd_counter_nd #(.NUM_DIGITS(ND), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clr(clr), .ena(ena), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q1), .carry_out(c1), .ovf(o1));
`endif

    function automatic bit [23:0] to_bcd(input int v);
        bit [23:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input bit [23:0] lv);
        int v;
        int d;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    // Drive one cycle, advance the model on the edge, return #1 after it.
    task automatic step(input bit c, input bit l, input bit [23:0] lv,
                        input bit e, input bit ud, input bit la);
        bit sat;
        clr = c; load = l; load_val = lv; ena = e; up_dn = ud; latch = la;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            sat = (k == 1);
            if (la) m_lat[k] = to_bcd(m_cnt[k]);
            else if (c) m_lat[k] = '0;
            m_car[k] = 1'b0;
            if (c) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = from_load(lv);
                m_ovf[k] = 1'b0;
            end else if (e) begin
                if (ud && m_cnt[k] == MAX) begin
                    m_ovf[k] = 1'b1;
                    if (!sat) begin m_cnt[k] = 0; m_car[k] = 1'b1; end
                end else if (!ud && m_cnt[k] == 0) begin
                    m_ovf[k] = 1'b1;
                    if (!sat) begin m_cnt[k] = MAX; m_car[k] = 1'b1; end
                end else begin
                    m_cnt[k] = ud ? m_cnt[k] + 1 : m_cnt[k] - 1;
                end
            end
        end
        #1;
        clr = 1'b0; load = 1'b0; latch = 1'b0;
    endtask

    task automatic test_reset;
        bit saw_carry;
        step(1, 0, '0, 0, 1, 0);
        checks++;
        if (q0 !== 24'h0 || c0 !== 1'b0 || o0 !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%h c=%b o=%b want 000000 0 0", q0, c0, o0);
        end
        saw_carry = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0, 1, 1, 0);
            if (c0 === 1'b1) saw_carry = 1'b1;
        end
        checks++;
        if (q0 !== 24'h000010 || o0 !== 1'b0 || saw_carry) begin
            errors++;
            $display("FAIL count10: q=%h o=%b carry_seen=%b want 000010 0 0", q0, o0, saw_carry);
        end
    endtask

    task automatic test_wrap_up;
        step(0, 1, 24'h999998, 0, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        checks++;
        if (q0 !== 24'h999999 || c0 !== 1'b0) begin
            errors++;
            $display("FAIL up_pre: q=%h c=%b want 999999 0", q0, c0);
        end
        step(0, 0, '0, 1, 1, 0);
        checks++;
        if (q0 !== 24'h000000 || c0 !== 1'b1 || o0 !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap: q=%h c=%b o=%b want 000000 1 1", q0, c0, o0);
        end
        checks++;
        if (q1 !== 24'h999999 || c1 !== 1'b0 || o1 !== 1'b1) begin
            errors++;
            $display("FAIL sat_up_hold: q=%h c=%b o=%b want 999999 0 1", q1, c1, o1);
        end
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 1, 0);
        checks++;
        if (q0 !== 24'h000005 || c0 !== 1'b0 || o0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: q=%h c=%b o=%b want 000005 0 1", q0, c0, o0);
        end
    endtask

    task automatic test_wrap_down;
        step(0, 1, 24'h000001, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        checks++;
        if (q0 !== 24'h000000 || c0 !== 1'b0 || o0 !== 1'b0) begin
            errors++;
            $display("FAIL dn_zero: q=%h c=%b o=%b want 000000 0 0", q0, c0, o0);
        end
        step(0, 0, '0, 1, 0, 0);
        checks++;
        if (q0 !== 24'h999999 || c0 !== 1'b1 || o0 !== 1'b1) begin
            errors++;
            $display("FAIL dn_wrap: q=%h c=%b o=%b want 999999 1 1", q0, c0, o0);
        end
        step(0, 0, '0, 1, 0, 0);
        checks++;
        if (q0 !== 24'h999998 || c0 !== 1'b0) begin
            errors++;
            $display("FAIL dn_after: q=%h c=%b want 999998 0", q0, c0);
        end
        checks++;
        if (q1 !== 24'h000000 || o1 !== 1'b1 || c1 !== 1'b0) begin
            errors++;
            $display("FAIL sat_dn_hold: q=%h c=%b o=%b want 000000 0 1", q1, c1, o1);
        end
    endtask

    task automatic test_load_clamp;
        step(0, 1, 24'h0A0F05, 0, 1, 0);
        checks++;
        if (q0 !== 24'h090905 || o0 !== 1'b0) begin
            errors++;
            $display("FAIL clamp: q=%h o=%b want 090905 0", q0, o0);
        end
        for (int i = 0; i < 5; i++) step(0, 0, '0, 0, 1, 0);
        checks++;
        if (q0 !== 24'h090905 || c0 !== 1'b0) begin
            errors++;
            $display("FAIL hold: q=%h c=%b want 090905 0", q0, c0);
        end
        step(1, 1, 24'h123456, 1, 1, 0);
        checks++;
        if (q0 !== 24'h0 || q1 !== 24'h0) begin
            errors++;
            $display("FAIL clr_over_load: q0=%h q1=%h want 000000", q0, q1);
        end
    endtask

    task automatic test_clr_suppress;
        step(0, 1, 24'h999999, 0, 1, 0);
        step(1, 0, '0, 1, 1, 0);
        checks++;
        if (q0 !== 24'h0 || c0 !== 1'b0 || o0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_wrap: q=%h c=%b o=%b want 000000 0 0", q0, c0, o0);
        end
        step(0, 1, 24'h999999, 0, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 0, 1, 0);
        checks++;
        if (q0 !== 24'h0 || c0 !== 1'b0 || o0 !== 1'b1) begin
            errors++;
            $display("FAIL carry_pulse: q=%h c=%b o=%b want 000000 0 1", q0, c0, o0);
        end
    endtask

    task automatic test_saturate;
        step(0, 1, 24'h999999, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1, 0);
        checks++;
        if (q1 !== 24'h999999 || c1 !== 1'b0 || o1 !== 1'b1) begin
            errors++;
            $display("FAIL sat_up: q=%h c=%b o=%b want 999999 0 1", q1, c1, o1);
        end
        step(0, 0, '0, 1, 0, 0);
        checks++;
        if (q1 !== 24'h999998 || o1 !== 1'b1) begin
            errors++;
            $display("FAIL sat_resume: q=%h o=%b want 999998 1", q1, o1);
        end
    endtask

`ifdef BCD_CNT_LATCH_EN
    task automatic test_latch;
        step(1, 0, '0, 0, 1, 0);
        step(0, 1, 24'h000120, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1, 0);
        step(1, 0, '0, 1, 1, 1);
        checks++;
        if (ql0 !== 24'h000123 || q0 !== 24'h0) begin
            errors++;
            $display("FAIL latch_clr: ql=%h q=%h want 000123 000000", ql0, q0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1, 0);
        checks++;
        if (ql0 !== 24'h000123 || q0 !== 24'h000004) begin
            errors++;
            $display("FAIL latch_hold: ql=%h q=%h want 000123 000004", ql0, q0);
        end
    endtask
`endif

    task automatic test_random;
        bit c, l, e, ud, la;
        bit [23:0] lv;
        int r;
        int bad;
        bad = 0;
        step(1, 0, '0, 0, 1, 0);
        for (int n = 0; n < 600; n++) begin
            c  = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            ud = ($urandom_range(0, 2) != 0);
            la = ($urandom_range(0, 7) == 0);
            r  = $urandom_range(0, 3);
            if (r == 0)      lv = 24'($urandom);
            else if (r == 1) lv = to_bcd(MAX - $urandom_range(0, 3));
            else if (r == 2) lv = to_bcd($urandom_range(0, 3));
            else             lv = to_bcd($urandom_range(0, MAX));
            step(c, l, lv, e, ud, la);
            checks++;
            if (q0 !== to_bcd(m_cnt[0]) || c0 !== m_car[0] || o0 !== m_ovf[0]) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_wrap n=%0d: q=%h c=%b o=%b want %h %b %b",
                             n, q0, c0, o0, to_bcd(m_cnt[0]), m_car[0], m_ovf[0]);
                bad++;
            end
            checks++;
            if (q1 !== to_bcd(m_cnt[1]) || c1 !== m_car[1] || o1 !== m_ovf[1]) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_sat n=%0d: q=%h c=%b o=%b want %h %b %b",
                             n, q1, c1, o1, to_bcd(m_cnt[1]), m_car[1], m_ovf[1]);
                bad++;
            end
`ifdef BCD_CNT_LATCH_EN
            checks++;
            if (ql0 !== m_lat[0] || ql1 !== m_lat[1]) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_latch n=%0d: ql0=%h ql1=%h want %h %h",
                             n, ql0, ql1, m_lat[0], m_lat[1]);
                bad++;
            end
`endif
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_car[k] = 0; m_ovf[k] = 0; m_lat[k] = '0;
        end
        @(negedge clk);
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_clamp();
        test_clr_suppress();
        test_saturate();
`ifdef BCD_CNT_LATCH_EN
        test_latch();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
